// File: rtl/mips_mem_unit.sv
// Unified word-organised instruction/data memory for the multicycle MIPS32 core.
// Fixed-latency request/ready handshake with misalignment and read/write-conflict reporting.
module mips_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_rd;
    logic          r_wr;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_go_resp;
    logic [AW+1:0] w_addr;
    logic [31:0]   w_wdata;
    logic          w_rd;
    logic          w_wr;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    // Upper address bits are deliberately ignored: the array aliases every 4*DEPTH_WORDS bytes.
    assign w_unused_addr = ^addr[31:AW+2];

    always_comb begin
        w_req = mem_read | mem_write;
        // With LATENCY==1 the access fires on the accepting edge, so it must use the live inputs.
        if (r_state == S_IDLE) begin
            w_addr  = addr[AW+1:0];
            w_wdata = wdata;
            w_rd    = mem_read;
            w_wr    = mem_write;
        end else begin
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_rd    = r_rd;
            w_wr    = r_wr;
        end
        w_go_resp = ((r_state == S_IDLE) && w_req && (LATENCY == 1)) ||
                    ((r_state == S_WAIT) && (r_cnt == CW'(1)));
        w_err     = (w_addr[1:0] != 2'b00) | (w_rd & w_wr);
        w_idx     = w_addr[AW+1:2];
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            ready <= w_go_resp;
            err   <= w_go_resp & w_err;
            if (w_go_resp && w_rd && !w_err) begin
                rdata <= r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr[AW+1:0];
                        r_wdata <= wdata;
                        r_rd    <= mem_read;
                        r_wr    <= mem_write;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= (LATENCY > 1) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is not reset; an access aborted by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (w_go_resp && w_wr && !w_err) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_mips_mem_unit.sv
// Directed bench for mips_mem_unit: three instances (LATENCY 2, 4, 1) driven from one vector table.
module tb_mips_mem_unit;

    localparam int LAT [3] = '{2, 4, 1};

    logic        clk;
    logic        rst;
    logic        rd_a    [3];
    logic        wr_a    [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic [31:0] rdata_a [3];
    logic        ready_a [3];
    logic        busy_a  [3];
    logic        err_a   [3];

    int n_vec = 0;
    int n_mis = 0;

    mips_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .mem_read(rd_a[0]), .mem_write(wr_a[0]),
        .addr(addr_a[0]), .wdata(wdata_a[0]), .rdata(rdata_a[0]),
        .ready(ready_a[0]), .busy(busy_a[0]), .err(err_a[0]));

    mips_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_read(rd_a[1]), .mem_write(wr_a[1]),
        .addr(addr_a[1]), .wdata(wdata_a[1]), .rdata(rdata_a[1]),
        .ready(ready_a[1]), .busy(busy_a[1]), .err(err_a[1]));

    mips_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_read(rd_a[2]), .mem_write(wr_a[2]),
        .addr(addr_a[2]), .wdata(wdata_a[2]), .rdata(rdata_a[2]),
        .ready(ready_a[2]), .busy(busy_a[2]), .err(err_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] a2;
        logic        e;
        logic [31:0] q;
    } vec_t;

    function automatic vec_t mk(int k, logic r, logic w, logic [31:0] a, logic [31:0] d,
                                logic [31:0] a2, logic e, logic [31:0] q);
        vec_t v;
        v.k = k; v.r = r; v.w = w; v.a = a; v.d = d; v.a2 = a2; v.e = e; v.q = q;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One handshake: hold the request until ready, perturb addr/wdata one cycle after acceptance.
    task automatic txn(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] a2,
                       output int lat, output int bcnt, output logic e,
                       output logic [31:0] q, output logic one_cycle);
        @(negedge clk);
        rd_a[k] = r; wr_a[k] = w; addr_a[k] = a; wdata_a[k] = d;
        lat = 0;
        bcnt = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy_a[k]) bcnt++;
            if (lat == 1) begin
                addr_a[k]  = a2;
                wdata_a[k] = ~d;
            end
        end while (!ready_a[k] && lat < 20);
        e = err_a[k];
        q = rdata_a[k];
        @(negedge clk);
        rd_a[k] = 1'b0; wr_a[k] = 1'b0;
        @(posedge clk);
        #1;
        one_cycle = !ready_a[k] && !err_a[k];
    endtask

    initial begin
        vec_t        tbl [21];
        int          lat;
        int          bc;
        logic        e;
        logic        oc;
        logic        seen;
        logic [31:0] q;

        tbl[0]  = mk(0, 1'b0, 1'b1, 32'h20,   32'h12345678, 32'h24,   1'b0, 32'h0BADF00D);
        tbl[1]  = mk(0, 1'b1, 1'b0, 32'h20,   32'h0,        32'h20,   1'b0, 32'h12345678);
        tbl[2]  = mk(0, 1'b0, 1'b1, 32'h1004, 32'hA5A5A5A5, 32'h1004, 1'b0, 32'h12345678);
        tbl[3]  = mk(0, 1'b1, 1'b0, 32'h4,    32'h0,        32'h4,    1'b0, 32'hA5A5A5A5);
        tbl[4]  = mk(0, 1'b1, 1'b0, 32'h22,   32'h0,        32'h22,   1'b1, 32'hA5A5A5A5);
        tbl[5]  = mk(0, 1'b0, 1'b1, 32'h21,   32'hFFFFFFFF, 32'h21,   1'b1, 32'hA5A5A5A5);
        tbl[6]  = mk(0, 1'b1, 1'b0, 32'h20,   32'h0,        32'h20,   1'b0, 32'h12345678);
        tbl[7]  = mk(0, 1'b1, 1'b0, 32'h4,    32'h0,        32'h4,    1'b0, 32'hA5A5A5A5);
        tbl[8]  = mk(0, 1'b1, 1'b1, 32'h20,   32'h0,        32'h20,   1'b1, 32'hA5A5A5A5);
        tbl[9]  = mk(0, 1'b1, 1'b0, 32'h20,   32'h0,        32'h20,   1'b0, 32'h12345678);
        tbl[10] = mk(0, 1'b0, 1'b1, 32'hFFC,  32'hCAFEF00D, 32'hFFC,  1'b0, 32'h12345678);
        tbl[11] = mk(0, 1'b1, 1'b0, 32'h1FFC, 32'h0,        32'h1FFC, 1'b0, 32'hCAFEF00D);
        tbl[12] = mk(0, 1'b1, 1'b0, 32'h1004, 32'h0,        32'h1004, 1'b0, 32'hA5A5A5A5);
        tbl[13] = mk(1, 1'b0, 1'b1, 32'h40,   32'h11112222, 32'h40,   1'b0, 32'h0);
        tbl[14] = mk(1, 1'b0, 1'b1, 32'h44,   32'h33334444, 32'h44,   1'b0, 32'h0);
        tbl[15] = mk(1, 1'b1, 1'b0, 32'h40,   32'h0,        32'h44,   1'b0, 32'h11112222);
        tbl[16] = mk(1, 1'b0, 1'b1, 32'h48,   32'h55556666, 32'h4C,   1'b0, 32'h11112222);
        tbl[17] = mk(1, 1'b1, 1'b0, 32'h48,   32'h0,        32'h48,   1'b0, 32'h55556666);
        tbl[18] = mk(2, 1'b0, 1'b1, 32'h8,    32'h5555AAAA, 32'h8,    1'b0, 32'h0);
        tbl[19] = mk(2, 1'b0, 1'b1, 32'hC,    32'h77778888, 32'hC,    1'b0, 32'h0);
        tbl[20] = mk(2, 1'b1, 1'b0, 32'h8,    32'h0,        32'h8,    1'b0, 32'h5555AAAA);

        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_a[k] = 1'b0; wr_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready_a[0]}, 32'h0);
        chk("rst_busy",  {31'b0, busy_a[0]},  32'h0);
        chk("rst_err",   {31'b0, err_a[0]},   32'h0);
        chk("rst_rdata", rdata_a[0], 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Seed 0x10 with a known value and leave it in rdata.
        txn(0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 32'h10, lat, bc, e, q, oc);
        chk("seed_wr_err", {31'b0, e}, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h10, lat, bc, e, q, oc);
        chk("seed_rd_data", q, 32'h0BADF00D);

        // Reset one cycle after a write is accepted.
        @(negedge clk);
        wr_a[0] = 1'b1; addr_a[0] = 32'h10; wdata_a[0] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        chk("abort_busy_before", {31'b0, busy_a[0]}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy",  {31'b0, busy_a[0]},  32'h0);
        chk("abort_rdata", rdata_a[0], 32'h0);
        wr_a[0] = 1'b0;
        seen = ready_a[0];
        repeat (2) begin
            @(posedge clk);
            #1;
            seen = seen | ready_a[0];
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | ready_a[0];
        end
        chk("abort_no_ready", {31'b0, seen}, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h10, lat, bc, e, q, oc);
        chk("abort_mem_kept", q, 32'h0BADF00D);

        for (int i = 0; i < 21; i++) begin
            txn(tbl[i].k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].a2, lat, bc, e, q, oc);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT[tbl[i].k]));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(LAT[tbl[i].k]));
            chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, tbl[i].e});
            chk($sformatf("v%0d_rdata", i), q, tbl[i].q);
            chk($sformatf("v%0d_single_pulse", i), {31'b0, oc}, 32'h1);
        end

        // LATENCY=1: a held read is re-accepted in the IDLE cycle right after RESP.
        @(negedge clk);
        rd_a[2] = 1'b1; addr_a[2] = 32'hC;
        @(posedge clk);
        #1;
        chk("b2b_ready1", {31'b0, ready_a[2]}, 32'h1);
        chk("b2b_data1",  rdata_a[2], 32'h77778888);
        @(negedge clk);
        addr_a[2] = 32'h8;
        @(posedge clk);
        #1;
        chk("b2b_idle_ready", {31'b0, ready_a[2]}, 32'h0);
        chk("b2b_idle_busy",  {31'b0, busy_a[2]},  32'h0);
        @(posedge clk);
        #1;
        chk("b2b_ready2", {31'b0, ready_a[2]}, 32'h1);
        chk("b2b_data2",  rdata_a[2], 32'h5555AAAA);
        @(negedge clk);
        rd_a[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_end_ready", {31'b0, ready_a[2]}, 32'h0);
        chk("b2b_end_busy",  {31'b0, busy_a[2]},  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
